// File: rtl/scramble_pkg.sv
// scramble_pkg
//   Shared definitions for the scramble engine:
//     state_t        - controller states
//     COMPL_*        - constants applied in the COMPL step, selected by r[3:2]
//     REDUCE_*       - mode select values for scramble_mod_reduce
package scramble_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLASS,
    MUL,
    SUM,
    RSUM,
    RSOT,
    COMPL,
    OUT
  } state_t;

  // COMPL update, indexed by r[3:2]: 00 -> -21, 01 -> -42, 10 -> +7, 11 -> +28
  localparam int COMPL_SUB_LO = 21;
  localparam int COMPL_SUB_HI = 42;
  localparam int COMPL_ADD_LO = 7;
  localparam int COMPL_ADD_HI = 28;

  // Reduction mode: RSUM subtracts MOD while acc > MOD,
  // RSOT adds MOD while acc is outside the symbol range.
  localparam logic REDUCE_RSUM = 1'b0;
  localparam logic REDUCE_RSOT = 1'b1;

endpackage

// File: rtl/scramble_mod_reduce.sv
// scramble_mod_reduce
//   One step of the modulo-reduction loop used by the RSUM and RSOT states.
//   Purely combinational; the caller registers acc_next every cycle it stays
//   in the loop state and leaves once done is high.
// Parameters:
//   W   - symbol width
//   AW  - accumulator width (W+3)
// Ports:
//   acc       in   AW  current accumulator
//   modulus   in   AW  key modulus MOD, zero-extended
//   mode      in   1   REDUCE_RSUM or REDUCE_RSOT
//   acc_next  out  AW  accumulator after one step (equals acc when done)
//   done      out  1   loop condition no longer holds
module scramble_mod_reduce
  import scramble_pkg::*;
#(
  parameter int W  = 6,
  parameter int AW = W + 3
) (
  input  logic [AW-1:0] acc,
  input  logic [AW-1:0] modulus,
  input  logic          mode,
  output logic [AW-1:0] acc_next,
  output logic          done
);

  // Largest value representable as a W-bit symbol, widened to AW.
  localparam logic [AW-1:0] SYM_MAX = AW'({W{1'b1}});

  always_comb begin
    acc_next = acc;
    done     = 1'b1;
    if (mode == REDUCE_RSUM) begin
      done = !(acc > modulus);
      if (!done) begin
        acc_next = acc - modulus;
      end
    end else begin
      // Wraps through 2^AW back into range; terminates because MOD < 2^W.
      done = !(acc > SYM_MAX);
      if (!done) begin
        acc_next = acc + modulus;
      end
    end
  end

endmodule

// File: rtl/scramble_engine.sv
// scramble_engine
//   Handshaked cipher scrambler. Each accepted W-bit symbol is classified as
//   pass-through (all zeros / all ones), scramble (1..MOD) or drop (> MOD).
//   Scrambled symbols run a multi-cycle key/modulo datapath; pass-through
//   symbols are returned unchanged and advance the key counter.
// Parameters:
//   W       - symbol width (>= 4)
//   key modulus parameter, legal range 1 .. 2^W-1
//   DROP_W  - drop counter width
// Ports:
//   clock      in   1       rising-edge clock
//   reset      in   1       synchronous active-high reset
//   in_valid   in   1       input symbol valid
//   in_data    in   W       input symbol
//   in_ready   out  1       engine idle and not in reset
//   out_valid  out  1       output symbol valid
//   out_data   out  W       output symbol (registered)
//   out_ready  in   1       sink accepts
//   drop_cnt   out  DROP_W  saturating count of dropped symbols
// Build option:
//   SCRAMBLE_ABS_EN - when defined, a scrambled result with the accumulator
//   MSB set is output as its two's-complement magnitude.
module scramble_engine
  import scramble_pkg::*;
#(
  parameter int W      = 6,
  parameter int MOD    = 26,
  parameter int DROP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [W-1:0]      in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [W-1:0]      out_data,
  input  logic              out_ready,
  output logic [DROP_W-1:0] drop_cnt
);

  localparam int AW = W + 3;
  localparam logic [AW-1:0] MOD_AW       = AW'(MOD);
  localparam logic [W-1:0]  CONT_LAST    = W'(MOD - 1);
  localparam logic [AW-1:0] C_SUB_LO     = AW'(COMPL_SUB_LO);
  localparam logic [AW-1:0] C_SUB_HI     = AW'(COMPL_SUB_HI);
  localparam logic [AW-1:0] C_ADD_LO     = AW'(COMPL_ADD_LO);
  localparam logic [AW-1:0] C_ADD_HI     = AW'(COMPL_ADD_HI);

  state_t              state_reg;
  state_t              state_next;
  logic [W-1:0]        r_reg;
  logic [AW-1:0]       acc_reg;
  logic [W-1:0]        cont_reg;
  logic [W-1:0]        out_data_reg;
  logic [DROP_W-1:0]   drop_cnt_reg;

  logic                accept;
  logic                is_pass;
  logic                in_range;
  logic [AW-1:0]       r_wide;
  logic [AW-1:0]       acc_mul;
  logic [AW-1:0]       acc_compl;
  logic [W-1:0]        out_scrambled;
  logic [AW-1:0]       reduce_acc;
  logic                reduce_done;
  logic                reduce_mode;

  // --------------------------------------------------------------------
  // Symbol classification and arithmetic helpers
  // --------------------------------------------------------------------
  assign accept   = in_valid && in_ready;
  assign r_wide   = AW'(r_reg);
  assign is_pass  = (r_reg == '0) || (r_reg == '1);
  assign in_range = (r_wide <= MOD_AW);

  // MUL step: key, doubled when r[0] is set.
  assign acc_mul = r_reg[0] ? {2'b00, cont_reg, 1'b0} : AW'(cont_reg);

  always_comb begin
    acc_compl = acc_reg;
    case (r_reg[3:2])
      2'b00:   acc_compl = acc_reg - C_SUB_LO;
      2'b01:   acc_compl = acc_reg - C_SUB_HI;
      2'b10:   acc_compl = acc_reg + C_ADD_LO;
      default: acc_compl = acc_reg + C_ADD_HI;
    endcase
  end

`ifdef SCRAMBLE_ABS_EN
  // Negative (MSB set) result is reported as its magnitude.
  assign out_scrambled = acc_compl[AW-1] ? W'(AW'(0) - acc_compl)
                                         : acc_compl[W-1:0];
`else
  assign out_scrambled = acc_compl[W-1:0];
`endif

  assign reduce_mode = (state_reg == RSOT) ? REDUCE_RSOT : REDUCE_RSUM;

  scramble_mod_reduce #(
    .W  (W),
    .AW (AW)
  ) u_mod_reduce (
    .acc      (acc_reg),
    .modulus  (MOD_AW),
    .mode     (reduce_mode),
    .acc_next (reduce_acc),
    .done     (reduce_done)
  );

  // --------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // --------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = CLASS;
        end
      end
      CLASS: begin
        if (is_pass) begin
          state_next = OUT;
        end else if (in_range) begin
          state_next = MUL;
        end else begin
          state_next = IDLE;
        end
      end
      MUL:   state_next = SUM;
      SUM:   state_next = r_reg[1] ? RSUM : RSOT;
      RSUM,
      RSOT: begin
        if (reduce_done) begin
          state_next = COMPL;
        end
      end
      COMPL: state_next = OUT;
      OUT: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_reg == IDLE) && !reset;
    out_valid = (state_reg == OUT);
  end

  assign out_data = out_data_reg;
  assign drop_cnt = drop_cnt_reg;

  // --------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg        <= '0;
      acc_reg      <= '0;
      cont_reg     <= '0;
      out_data_reg <= '0;
      drop_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (accept) begin
            r_reg <= in_data;
          end
        end
        CLASS: begin
          if (is_pass) begin
            acc_reg      <= r_wide;
            out_data_reg <= r_reg;
            // The key only advances on pass-through symbols.
            cont_reg     <= (cont_reg < CONT_LAST) ? cont_reg + W'(1) : '0;
          end else if (!in_range) begin
            if (drop_cnt_reg != '1) begin
              drop_cnt_reg <= drop_cnt_reg + DROP_W'(1);
            end
          end
        end
        MUL: begin
          acc_reg <= acc_mul;
        end
        SUM: begin
          acc_reg <= r_reg[1] ? (r_wide + acc_reg) : (r_wide - acc_reg);
        end
        RSUM,
        RSOT: begin
          acc_reg <= reduce_acc;
        end
        COMPL: begin
          acc_reg      <= acc_compl;
          out_data_reg <= out_scrambled;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_scramble_engine.sv
// tb_scramble_engine
//   Self-checking bench for scramble_engine (W=6, MOD=26, DROP_W=8).
//   Latency convention: a symbol accepted at edge T has latency n when the
//   sink first samples the awaited signal high at edge T+n.
module tb_scramble_engine;

  localparam int W      = 6;
  localparam int MOD    = 26;
  localparam int DROP_W = 8;
  localparam int SYM_MAX  = (1 << W) - 1;
  localparam int ACC_MOD  = 1 << (W + 3);
  localparam int DROP_MAX = (1 << DROP_W) - 1;

`ifdef SCRAMBLE_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [W-1:0]      out_data;
  logic              out_ready = 1'b1;
  logic [DROP_W-1:0] drop_cnt;

  always #5 clock = ~clock;

  scramble_engine #(
    .W      (W),
    .MOD    (MOD),
    .DROP_W (DROP_W)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .drop_cnt  (drop_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: key counter and drop count.
  int m_cont = 0;
  int m_drop = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Behavioural model of one symbol: plain integer arithmetic on the rules.
  function automatic void model_step(input int sym, output int exp_out,
                                     output int exp_lat, output bit exp_drop);
    int a;
    int k;
    k        = 0;
    exp_drop = 1'b0;
    exp_out  = 0;
    exp_lat  = 2;
    if (sym == 0 || sym == SYM_MAX) begin
      exp_out = sym;
      m_cont  = (m_cont < MOD - 1) ? m_cont + 1 : 0;
    end else if (sym > MOD) begin
      exp_drop = 1'b1;
      if (m_drop < DROP_MAX) m_drop++;
    end else begin
      a = (sym % 2 == 1) ? 2 * m_cont : m_cont;
      if ((sym / 2) % 2 == 1) begin
        a = (sym + a) % ACC_MOD;
        while (a > MOD) begin a = a - MOD; k++; end
      end else begin
        a = (sym - a + ACC_MOD) % ACC_MOD;
        while (a > SYM_MAX) begin a = (a + MOD) % ACC_MOD; k++; end
      end
      case ((sym / 4) % 4)
        0:       a = a - 21;
        1:       a = a - 42;
        2:       a = a + 7;
        default: a = a + 28;
      endcase
      a = ((a % ACC_MOD) + ACC_MOD) % ACC_MOD;
      exp_out = a % (SYM_MAX + 1);
      if (ABS && a >= ACC_MOD / 2) exp_out = (ACC_MOD - a) % (SYM_MAX + 1);
      exp_lat = 6 + k;
    end
  endfunction

  task automatic do_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    check("reset_in_ready", int'(in_ready), 0);
    @(negedge clock);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data", int'(out_data), 0);
    check("reset_drop_cnt", int'(drop_cnt), 0);
    reset  = 1'b0;
    m_cont = 0;
    m_drop = 0;
    #1;
    check("post_reset_in_ready", int'(in_ready), 1);
  endtask

  // Offer one symbol, then check latency, data, backpressure hold and the
  // return to idle. hold>0 keeps out_ready low for that many cycles.
  task automatic send(input int sym, input int exp_out, input int exp_lat,
                      input bit exp_drop, input int hold, input string tag);
    int e;
    bit seen;
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    in_data   = W'(sym);
    e = 0;
    while (!in_ready && e < 50) begin @(negedge clock); e++; end
    check({tag, "_accept"}, int'(in_ready), 1);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    e    = 0;
    seen = 1'b0;
    if (exp_drop) begin
      while (!in_ready && e < 20) begin
        if (out_valid) seen = 1'b1;
        @(negedge clock);
        e++;
      end
      check({tag, "_ready_lat"}, e + 1, exp_lat);
      check({tag, "_no_output"}, int'(seen), 0);
      check({tag, "_drop_cnt"}, int'(drop_cnt), m_drop);
      $display("txn %s sym=%0d dropped drop_cnt=%0d lat=%0d", tag, sym, drop_cnt, e + 1);
    end else begin
      while (!out_valid && e < 100) begin @(negedge clock); e++; end
      check({tag, "_valid_lat"}, e + 1, exp_lat);
      check({tag, "_data"}, int'(out_data), exp_out);
      $display("txn %s sym=%0d out=%0d lat=%0d hold=%0d", tag, sym, out_data, e + 1, hold);
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check({tag, "_hold_valid"}, int'(out_valid), 1);
        check({tag, "_hold_data"}, int'(out_data), exp_out);
        check({tag, "_hold_in_ready"}, int'(in_ready), 0);
      end
      out_ready = 1'b1;
      @(negedge clock);
      check({tag, "_done_valid"}, int'(out_valid), 0);
      check({tag, "_done_in_ready"}, int'(in_ready), 1);
    end
  endtask

  task automatic send_model(input int sym, input int hold, input string tag);
    int eo;
    int el;
    bit ed;
    model_step(sym, eo, el, ed);
    send(sym, eo, el, ed, hold, tag);
  endtask

  // Pass-through with spec-fixed expectations; model tracks the key.
  task automatic send_pass(input int sym, input string tag);
    int eo;
    int el;
    bit ed;
    model_step(sym, eo, el, ed);
    send(sym, sym, 2, 1'b0, 0, tag);
  endtask

  typedef struct {
    bit do_reset;
    int sym;
    int exp_out;
    int exp_lat;
    bit exp_drop;
    int exp_cnt;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int eo;
    int el;
    bit ed;
    bit seen;

    vecs[0] = '{1'b1, 0,  0,  2, 1'b0, 0};
    vecs[1] = '{1'b0, 63, 63, 2, 1'b0, 0};
    vecs[2] = '{1'b0, 14, 44, 6, 1'b0, 0};
    vecs[3] = '{1'b0, 27, 0,  2, 1'b1, 1};
    vecs[4] = '{1'b1, 5,  ABS ? 37 : 27, 6, 1'b0, 0};
    vecs[5] = '{1'b0, 63, 63, 2, 1'b0, 0};

    do_reset();

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].do_reset) do_reset();
      model_step(vecs[i].sym, eo, el, ed);
      send(vecs[i].sym, vecs[i].exp_out, vecs[i].exp_lat, vecs[i].exp_drop, 0,
           $sformatf("vec%0d", i));
      if (vecs[i].exp_drop) check($sformatf("vec%0d_cnt", i), int'(drop_cnt), vecs[i].exp_cnt);
    end

    // cont=25 then symbol 3: two RSUM iterations.
    do_reset();
    for (int i = 0; i < 25; i++) send_pass((i % 2 == 0) ? 0 : 63, $sformatf("cont_up%0d", i));
    model_step(3, eo, el, ed);
    send(3, ABS ? 20 : 44, 8, 1'b0, 0, "rsum_k2");

    // Key wrap: 26 pass-throughs bring cont back to 0.
    do_reset();
    for (int i = 0; i < 26; i++) send_pass((i % 2 == 0) ? 63 : 0, $sformatf("wrap%0d", i));
    model_step(5, eo, el, ed);
    send(5, ABS ? 37 : 27, 6, 1'b0, 0, "wrap_sym5");

    // Backpressure: out_ready low for 5 cycles.
    send_model(14, 5, "bp14");
    send_model(1, 5, "bp1");

    // Reset while in RSUM: no output, everything back to reset values.
    do_reset();
    send_model(27, 0, "pre_drop");
    for (int i = 0; i < 25; i++) send_pass(63, $sformatf("pre_rst%0d", i));
    in_valid = 1'b1;
    in_data  = W'(3);
    @(posedge clock);
    @(negedge clock);
    in_valid = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("rst_rsum_out_valid", int'(out_valid), 0);
    check("rst_rsum_out_data", int'(out_data), 0);
    check("rst_rsum_drop_cnt", int'(drop_cnt), 0);
    check("rst_rsum_in_ready", int'(in_ready), 0);
    reset  = 1'b0;
    m_cont = 0;
    m_drop = 0;
    seen   = 1'b0;
    repeat (10) begin
      @(negedge clock);
      if (out_valid) seen = 1'b1;
    end
    check("rst_rsum_no_output", int'(seen), 0);
    check("rst_rsum_idle", int'(in_ready), 1);
    $display("txn rst_rsum aborted out_data=%0d drop_cnt=%0d", out_data, drop_cnt);
    send_model(5, 0, "after_rst");

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 300; i++) send_model($urandom_range(MOD + 1, SYM_MAX - 1), 0,
                                             $sformatf("drop%0d", i));
    check("drop_saturated", int'(drop_cnt), DROP_MAX);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      int sym;
      int hold;
      sym  = $urandom_range(0, SYM_MAX);
      hold = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
      send_model(sym, hold, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
